// File: rtl/shot_clock_display.sv
`default_nettype none
// ============================================================================
//  Module   : shot_clock_display
//  Purpose  : Two-digit multiplexed 7-segment driver with leading-zero blanking
//             for the possession countdown, plus a fixed-length buzzer pulse.
//  Revision : 1.0  initial release
// ============================================================================
module shot_clock_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int BUZZ_CYCLES = 50000000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [4:0] valor,
    input  logic       buzzer_in,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       buzzer_out
);
    localparam int                 c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                 c_BUZZ_W    = $clog2(BUZZ_CYCLES + 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BUZZ_W-1:0] c_BUZZ_LOAD = c_BUZZ_W'(BUZZ_CYCLES);
    localparam logic [c_BUZZ_W-1:0] c_BUZZ_ONE  = c_BUZZ_W'(1);
    localparam logic [6:0]          c_BLANK     = 7'b1111111;

    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic                r_dig;
    logic                r_first;
    logic [4:0]          r_snap;
    logic                r_buz_prev;
    logic [c_BUZZ_W-1:0] r_buz_cnt;
    logic [6:0]          r_seg;
    logic [1:0]          r_dig_sel;
    logic                r_buzzer_out;

    logic                w_wrap;
    logic [1:0]          w_tens;
    logic [4:0]          w_sub;
    logic [4:0]          w_units;
    logic [6:0]          w_seg_next;
    logic [1:0]          w_dig_sel_next;
    logic                w_buz_rise;
    logic [c_BUZZ_W-1:0] w_buz_cnt_next;

    function automatic logic [6:0] seg_code(input logic [4:0] d);
        case (d)
            5'd0:    seg_code = 7'b1000000;
            5'd1:    seg_code = 7'b1111001;
            5'd2:    seg_code = 7'b0100100;
            5'd3:    seg_code = 7'b0110000;
            5'd4:    seg_code = 7'b0011001;
            5'd5:    seg_code = 7'b0010010;
            5'd6:    seg_code = 7'b0000010;
            5'd7:    seg_code = 7'b1111000;
            5'd8:    seg_code = 7'b0000000;
            5'd9:    seg_code = 7'b0010000;
            default: seg_code = c_BLANK;
        endcase
    endfunction

    assign w_wrap     = (r_scan_cnt == c_SCAN_LAST);
    assign w_buz_rise = buzzer_in & ~r_buz_prev;

    always_comb begin
        w_tens = 2'd0;
        w_sub  = 5'd0;
        if (r_snap >= 5'd30) begin
            w_tens = 2'd3;
            w_sub  = 5'd30;
        end else if (r_snap >= 5'd20) begin
            w_tens = 2'd2;
            w_sub  = 5'd20;
        end else if (r_snap >= 5'd10) begin
            w_tens = 2'd1;
            w_sub  = 5'd10;
        end
        w_units = r_snap - w_sub;
    end

    // The snapshot cycle right after reset keeps the display blank so the
    // first units slot shows the fresh snapshot for its full length.
    always_comb begin
        w_seg_next     = c_BLANK;
        w_dig_sel_next = 2'b11;
        if (!r_first) begin
            if (!r_dig) begin
                w_seg_next     = seg_code(w_units);
                w_dig_sel_next = 2'b10;
            end else if (w_tens != 2'd0) begin
                w_seg_next     = seg_code({3'b000, w_tens});
                w_dig_sel_next = 2'b01;
            end
        end
    end

    always_comb begin
        w_buz_cnt_next = r_buz_cnt;
        if (w_buz_rise) begin
            w_buz_cnt_next = c_BUZZ_LOAD;
        end else if (r_buz_cnt != '0) begin
            w_buz_cnt_next = r_buz_cnt - c_BUZZ_ONE;
        end
    end

    always_ff @(posedge clock_in) begin
        r_buz_prev <= buzzer_in;
        if (reset) begin
            r_scan_cnt   <= '0;
            r_dig        <= 1'b0;
            r_first      <= 1'b1;
            r_snap       <= 5'd0;
            r_buz_cnt    <= '0;
            r_seg        <= c_BLANK;
            r_dig_sel    <= 2'b11;
            r_buzzer_out <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dig_sel    <= w_dig_sel_next;
            r_buz_cnt    <= w_buz_cnt_next;
            r_buzzer_out <= (w_buz_cnt_next != '0);
            if (r_first) begin
                r_first <= 1'b0;
                r_snap  <= valor;
            end else if (w_wrap) begin
                r_scan_cnt <= '0;
                r_dig      <= ~r_dig;
                if (r_dig) begin
                    r_snap <= valor;
                end
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig_sel;
    assign buzzer_out = r_buzzer_out;

endmodule
`default_nettype wire
